// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing source for a VGA output.
// Produces the pixel/line counters consumed by the scene renderer. The renderer
// hands back a registered pixel, and this block delays sync and blanking so that
// hsync, vsync, blank and rgb_out all line up with that pixel. The colour is
// forced to zero outside the visible area.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 2,
  parameter int PIX_LAT  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] hcount,
  output logic [9:0] vcount,
  input  logic [7:0] pixel_in,
  output logic       hsync,
  output logic       vsync,
  output logic       blank,
  output logic [7:0] rgb_out,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Last counter values before wrapping (both totals are at most 1024).
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode thresholds are 11 bits wide so a sync pulse ending exactly at 1024
  // (zero back porch on a 1024-wide raster) still compares correctly.
  localparam logic [10:0] H_VIS_END  = 11'(H_ACTIVE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_ACTIVE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

  // Divider width stays at least one bit even when CLK_DIV is 1.
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0]      div_cnt;
  logic               pix_en;
  logic               h_wrap;
  logic               v_wrap;
  logic               vis0;
  logic               hs0;
  logic               vs0;
  logic [PIX_LAT-1:0] vis_d;
  logic [PIX_LAT-1:0] hs_d;
  logic [PIX_LAT-1:0] vs_d;
  logic [10:0]        h_ext;
  logic [10:0]        v_ext;

  assign pix_en = (div_cnt == DIV_LAST);
  assign h_wrap = (hcount == H_LAST);
  assign v_wrap = (vcount == V_LAST);
  assign h_ext  = {1'b0, hcount};
  assign v_ext  = {1'b0, vcount};

  // Clock divider: one pixel enable every CLK_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Raster counters: column advances on each pixel enable, line on column wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        hcount <= '0;
        if (v_wrap) begin
          vcount <= '0;
        end else begin
          vcount <= vcount + 10'd1;
        end
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  // Frame start marks the first clock at (0,0) after a genuine wrap, never a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_wrap && v_wrap;
    end
  end

  // Stage-0 decode of visibility and both sync pulses from the current counters.
  always_comb begin
    vis0 = 1'b0;
    hs0  = 1'b1;
    vs0  = 1'b1;
    if ((h_ext < H_VIS_END) && (v_ext < V_VIS_END)) begin
      vis0 = 1'b1;
    end
    if ((h_ext >= H_SYNC_BEG) && (h_ext < H_SYNC_END)) begin
      hs0 = 1'b0;
    end
    if ((v_ext >= V_SYNC_BEG) && (v_ext < V_SYNC_END)) begin
      vs0 = 1'b0;
    end
  end

  // Delay line matching the renderer latency; shifts every clock, not per pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vis_d <= '0;
      hs_d  <= '1;
      vs_d  <= '1;
    end else begin
      vis_d[0] <= vis0;
      hs_d[0]  <= hs0;
      vs_d[0]  <= vs0;
      for (int i = 1; i < PIX_LAT; i++) begin
        vis_d[i] <= vis_d[i-1];
        hs_d[i]  <= hs_d[i-1];
        vs_d[i]  <= vs_d[i-1];
      end
    end
  end

  // Output registers: syncs, blanking and the gated renderer pixel leave together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync   <= 1'b1;
      vsync   <= 1'b1;
      blank   <= 1'b1;
      rgb_out <= 8'h00;
    end else begin
      hsync   <= hs_d[PIX_LAT-1];
      vsync   <= vs_d[PIX_LAT-1];
      blank   <= ~vis_d[PIX_LAT-1];
      rgb_out <= vis_d[PIX_LAT-1] ? pixel_in : 8'h00;
    end
  end

endmodule
